// File: rtl/sha256_msg_padder.sv
// SHA-256 single-block padder: reads the message from SRAM and streams W0..W15 as 32-bit words.
// Each word is valid 5 cycles after go or after the previous handshake; valid holds and SRAM reads stall while ready is low.
module sha256_msg_padder #(
   parameter int MAX_MESSAGE_LENGTH = 55,
   parameter int SYMBOL_WIDTH       = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  xxx__dut__go,
   input  logic [$clog2(MAX_MESSAGE_LENGTH):0]   xxx__dut__msg_length,
   output logic [$clog2(MAX_MESSAGE_LENGTH)-1:0] dut__msg__address,
   output logic                                  dut__msg__enable,
   output logic                                  dut__msg__write,
   input  logic [SYMBOL_WIDTH-1:0]               msg__dut__data,
   output logic                                  pad__core__valid,
   input  logic                                  core__pad__ready,
   output logic [31:0]                           pad__core__data,
   output logic [3:0]                            pad__core__index,
   output logic                                  pad__core__last,
   output logic                                  pad__xxx__busy,
   output logic                                  pad__xxx__done
);

   localparam int LW = $clog2(MAX_MESSAGE_LENGTH) + 1;
   localparam int AW = $clog2(MAX_MESSAGE_LENGTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

   state_t          state_q;
   logic [LW-1:0]   len_q;
   logic [3:0]      k_q;
   logic [2:0]      phase_q;
   logic [23:0]     word_q;
   logic [AW-1:0]   addr_q;
   logic            en_q;
   logic            valid_q;
   logic [31:0]     data_q;
   logic [3:0]      index_q;
   logic            last_q;
   logic            busy_q;
   logic            done_q;

   logic [LW-1:0]   len_clamp;
   logic [5:0]      byte_idx;
   logic [5:0]      fetch_idx;
   logic [5:0]      next_word_idx;
   logic [63:0]     bit_len;
   logic [5:0]      len_shift;
   logic [7:0]      pad_byte;
   logic [23:0]     word_d;

   always_comb begin
      len_clamp     = (xxx__dut__msg_length > LW'(MAX_MESSAGE_LENGTH)) ? LW'(MAX_MESSAGE_LENGTH)
                                                                      : xxx__dut__msg_length;
      // Byte being captured lags the phase by one: SRAM data returns a cycle after the read.
      byte_idx      = {k_q, 2'(phase_q - 3'd1)};
      fetch_idx     = {k_q, 2'(phase_q[1:0] + 2'd1)};
      next_word_idx = {4'(k_q + 4'd1), 2'b00};
      bit_len       = 64'(len_q) << 3;
      len_shift     = {3'(6'd63 - byte_idx), 3'b000};
      pad_byte      = 8'h00;
      if (LW'(byte_idx) < len_q) begin
         pad_byte = 8'(msg__dut__data);
      end else if (LW'(byte_idx) == len_q) begin
         pad_byte = 8'h80;
      end else if (byte_idx >= 6'd56) begin
         pad_byte = 8'(bit_len >> len_shift);
      end
      word_d        = {word_q[15:0], pad_byte};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         k_q     <= '0;
         phase_q <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            // DONE also samples go so a held go restarts on the cycle DONE is left.
            S_IDLE, S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               if (state_q == S_DONE) begin
                  busy_q <= 1'b0;
               end
               if (xxx__dut__go) begin
                  state_q <= S_FETCH;
                  busy_q  <= 1'b1;
                  len_q   <= len_clamp;
                  k_q     <= '0;
                  phase_q <= '0;
                  if (len_clamp != '0) begin
                     en_q   <= 1'b1;
                     addr_q <= '0;
                  end
               end
            end
            S_FETCH: begin
               if (phase_q != 3'd0) begin
                  word_q <= word_d;
               end
               if (phase_q == 3'd4) begin
                  state_q <= S_PRESENT;
                  valid_q <= 1'b1;
                  data_q  <= {word_q, pad_byte};
                  index_q <= k_q;
                  last_q  <= (k_q == 4'd15);
               end else begin
                  phase_q <= phase_q + 3'd1;
                  if (phase_q != 3'd3 && LW'(fetch_idx) < len_q) begin
                     en_q   <= 1'b1;
                     addr_q <= AW'(fetch_idx);
                  end else begin
                     en_q <= 1'b0;
                  end
               end
            end
            S_PRESENT: begin
               if (core__pad__ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (k_q == 4'd15) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                     k_q     <= k_q + 4'd1;
                     phase_q <= '0;
                     if (LW'(next_word_idx) < len_q) begin
                        en_q   <= 1'b1;
                        addr_q <= AW'(next_word_idx);
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dut__msg__address = addr_q;
   assign dut__msg__enable  = en_q;
   assign dut__msg__write   = 1'b0;
   assign pad__core__valid  = valid_q;
   assign pad__core__data   = data_q;
   assign pad__core__index  = index_q;
   assign pad__core__last   = last_q;
   assign pad__xxx__busy    = busy_q;
   assign pad__xxx__done    = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: SRAM model, word scoreboard and read monitor.
module tb_sha256_msg_padder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        go = 1'b0;
   logic [6:0]  msg_length = '0;
   logic [5:0]  address;
   logic        enable;
   logic        write;
   logic [7:0]  rdata = '0;
   logic        valid;
   logic        ready = 1'b1;
   logic [31:0] data;
   logic [3:0]  index;
   logic        last;
   logic        busy;
   logic        done;

   sha256_msg_padder dut (
      .clk                  (clk),
      .reset                (reset),
      .xxx__dut__go         (go),
      .xxx__dut__msg_length (msg_length),
      .dut__msg__address    (address),
      .dut__msg__enable     (enable),
      .dut__msg__write      (write),
      .msg__dut__data       (rdata),
      .pad__core__valid     (valid),
      .core__pad__ready     (ready),
      .pad__core__data      (data),
      .pad__core__index     (index),
      .pad__core__last      (last),
      .pad__xxx__busy       (busy),
      .pad__xxx__done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dat;
      logic [3:0]  idx;
      logic        lst;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mem [64];
   logic [31:0] ew [16];
   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          hs15_cyc = -1;
   int          exp_addr = 0;
   int          rd_cnt = 0;
   int          last_rd_cnt = -1;

   // Registered SRAM: data for an enabled address appears the cycle after the edge; junk otherwise.
   always @(posedge clk) begin
      rdata <= enable ? mem[address] : 8'($urandom);
      cyc   <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         exp_addr = 0;
         rd_cnt   = 0;
      end else begin
         if (enable) begin
            chk("read_address", 64'(address), 64'(exp_addr));
            exp_addr++;
            rd_cnt++;
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("word_data", 64'(data), 64'(e.dat));
               chk("word_index", 64'(index), 64'(e.idx));
               chk("word_last", 64'(last), 64'(e.lst));
               if (last) hs15_cyc = cyc + 1;
            end
         end
         if (done) begin
            last_rd_cnt = rd_cnt;
            rd_cnt      = 0;
            exp_addr    = 0;
         end
      end
   end

   function automatic logic [31:0] model_word(input int k, input int lp);
      logic [31:0] w;
      logic [63:0] bl;
      logic [7:0]  b;
      w  = '0;
      bl = 64'(lp) * 64'd8;
      for (int j = 0; j < 4; j++) begin
         int i;
         i = 4 * k + j;
         if (i < lp) b = mem[i];
         else if (i == lp) b = 8'h80;
         else if (i >= 56) b = 8'(bl >> (8 * (63 - i)));
         else b = 8'h00;
         w = {w[23:0], b};
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_ew();
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back('{dat: ew[k], idx: 4'(k), lst: (k == 15)});
      end
   endtask

   task automatic fill_zero();
      for (int k = 0; k < 16; k++) ew[k] = '0;
   endtask

   task automatic fill_model(input int lp);
      for (int k = 0; k < 16; k++) ew[k] = model_word(k, lp);
   endtask

   task automatic check_latency(input string tag);
      int c;
      c = 0;
      while (!valid && c < 50) begin
         step();
         c++;
      end
      chk(tag, 64'(c), 64'd5);
   endtask

   task automatic start_run(input int len, input bit hold);
      msg_length = 7'(len);
      go = 1'b1;
      step();
      if (!hold) go = 1'b0;
      check_latency("first_valid_latency");
   endtask

   task automatic wait_idx(input int idx);
      int t;
      t = 0;
      while (!(valid && index == 4'(idx)) && t < 100) begin
         step();
         t++;
      end
      chk("wait_word", 64'({valid, index}), 64'({1'b1, 4'(idx)}));
   endtask

   task automatic finish_run(input int n_reads, input bit go_held);
      int t;
      t = 0;
      while (!done && t < 300) begin
         step();
         t++;
      end
      chk("done_seen", 64'(done), 64'd1);
      chk("done_after_w15", 64'(cyc), 64'(hs15_cyc));
      chk("busy_during_done", 64'(busy), 64'd1);
      step();
      chk("done_one_cycle", 64'(done), 64'd0);
      if (go_held) chk("rego_at_done_exit", 64'({busy, enable, address}), 64'({1'b1, 1'b1, 6'd0}));
      else chk("busy_fall", 64'(busy), 64'd0);
      chk("read_count", 64'(last_rd_cnt), 64'(n_reads));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("write_low", 64'(write), 64'd0);
   endtask

   task automatic fill_abc();
      fill_zero();
      ew[0]  = 32'h61626380;
      ew[15] = 32'h00000018;
   endtask

   initial begin
      logic [36:0] snap;
      for (int i = 0; i < 64; i++) mem[i] = 8'(32'h61 + i);
      #1 reset = 1'b1;
      repeat (3) step();
      chk("reset_outputs", 64'({valid, data, index, last, busy, done, enable, address, write}), 64'd0);
      reset = 1'b0;
      step();

      // "abc" with go held: second identical run starts as DONE is left
      fill_abc();
      push_ew();
      start_run(3, 1'b1);
      finish_run(3, 1'b1);
      fill_abc();
      push_ew();
      go = 1'b0;
      check_latency("rego_first_valid_latency");
      finish_run(3, 1'b0);

      // empty message
      fill_zero();
      ew[0] = 32'h80000000;
      push_ew();
      start_run(0, 1'b0);
      finish_run(0, 1'b0);

      // "abcd" with backpressure on W3 and a go during W7
      fill_zero();
      ew[0]  = 32'h61626364;
      ew[1]  = 32'h80000000;
      ew[15] = 32'h00000020;
      push_ew();
      start_run(4, 1'b0);
      wait_idx(2);
      step();
      ready = 1'b0;
      wait_idx(3);
      snap = {data, index, last};
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold", 64'({valid, data, index, last, enable}), 64'({1'b1, snap, 1'b0}));
      end
      ready = 1'b1;
      step();
      check_latency("bp_resume_latency");
      chk("bp_resume_index", 64'(index), 64'd4);
      wait_idx(7);
      go = 1'b1;
      repeat (10) step();
      go = 1'b0;
      finish_run(4, 1'b0);

      // maximum length, then an over-long request that clamps to it
      for (int r = 0; r < 2; r++) begin
         fill_model(55);
         ew[13] = 32'h95969780;
         ew[14] = 32'h00000000;
         ew[15] = 32'h000001B8;
         push_ew();
         start_run(r == 0 ? 55 : 60, 1'b0);
         finish_run(55, 1'b0);
      end

      // reset during FETCH of W5, then a clean "abc" block
      fill_model(55);
      push_ew();
      start_run(55, 1'b0);
      wait_idx(4);
      step();
      #1 reset = 1'b1;
      #1 chk("reset_abort", 64'({valid, data, index, last, busy, done, enable, address, write}), 64'd0);
      exp_q.delete();
      step();
      step();
      reset = 1'b0;
      step();
      fill_abc();
      push_ew();
      start_run(3, 1'b0);
      finish_run(3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
